// File: rtl/rxframer.sv
// USRT receive framer: samples the line on each bit strobe and assembles start/data/parity/stop into an 11-bit frame.
// Optional USRT_RX_SYNC_EN adds a two-flop input synchronizer (reset high) ahead of the line sampler.
`timescale 1ns/1ps
module rxframer (
  input  logic        i_Pclk,
  input  logic        i_Rst_n,
  input  logic        i_BitEn,
  input  logic        i_Rx,
  input  logic [1:0]  i_Parity,
  output logic [10:0] o_Frame,
  output logic        o_Valid,
  output logic        o_FrameErr,
  output logic        o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAITHI
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  par_q, par_d;
  logic [9:0]  asm_q, asm_d;
  logic [10:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        rx_s;

`ifdef USRT_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], i_Rx};
  assign rx_s   = sync_q[1];

  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) sync_q <= '1;
    else          sync_q <= sync_d;
  end
`else
  assign rx_s = i_Rx;
`endif

  // asm_q mirrors o_Frame[10:1]: [0] start, [8:1] data, [9] parity
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    asm_d   = asm_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    if (i_BitEn) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            asm_d    = '0;
            asm_d[0] = rx_s;
            par_d    = i_Parity;
            cnt_d    = '0;
            state_d  = S_DATA;
          end
        end
        S_DATA: begin
          asm_d[{1'b0, cnt_q} + 4'd1] = rx_s;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = (par_q == 2'b01 || par_q == 2'b10) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          asm_d[9] = rx_s;
          state_d  = S_STOP;
        end
        S_STOP: begin
          frame_d = {asm_q, rx_s};
          valid_d = 1'b1;
          ferr_d  = ~rx_s;
          state_d = rx_s ? S_IDLE : S_WAITHI;
        end
        S_WAITHI: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      par_q   <= '0;
      asm_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      asm_q   <= asm_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Frame    = frame_q;
  assign o_Valid    = valid_q;
  assign o_FrameErr = ferr_q;
  assign o_Busy     = busy_q;

endmodule

// File: doc/rxframer.md
# rxframer

Receive framer for the USRT receive path. It samples the serial receive line once per bit-enable strobe and detects the start bit. It shifts in 8 data bits LSB first, the optional parity bit and the stop bit. It then presents the complete 11-bit frame to the downstream parity checker (`rxparity`) with a one-cycle valid pulse and a framing-error flag.

## Interface

Parameters:
- none.

Ports (clock and reset first):
- `i_Pclk` — in, 1 — system clock; all logic on the rising edge.
- `i_Rst_n` — in, 1 — reset, synchronous, active-low.
- `i_BitEn` — in, 1 — bit-sample strobe; one line sample per cycle it is high; may be high on consecutive cycles.
- `i_Rx` — in, 1 — serial receive line; idles high.
- `i_Parity` — in, 2 — parity type: 00 or 11 none, 01 even, 10 odd. Latched at start-bit detection.
- `o_Frame` — out, 11 — assembled frame; same layout `rxparity` consumes:
  - [0] stop bit
  - [1] start bit
  - [9:2] data, data bit k at [2+k]
  - [10] parity bit; 0 when no parity
- `o_Valid` — out, 1 — one-cycle pulse; `o_Frame` and `o_FrameErr` are new.
- `o_FrameErr` — out, 1 — stop bit sampled 0; qualified by `o_Valid`; held until the next `o_Valid`.
- `o_Busy` — out, 1 — high in every state except IDLE.

## Operation

State machine: IDLE, DATA, PARITY, STOP, WAITHI. All transitions occur only on cycles with `i_BitEn`=1.
- **IDLE**
  - Tick with sampled rx=0: store start bit, latch `i_Parity`, clear the bit counter, go to DATA.
  - Tick with rx=1: stay in IDLE.
- **DATA**
  - Each tick shifts rx into data bit [counter]; the 3-bit counter runs 0..7.
  - After the tick at counter=7: go to PARITY if the latched parity is 01 or 10, else go to STOP.
- **PARITY**
  - One tick stores rx into the parity bit, then go to STOP.
- **STOP**
  - One tick stores rx as the stop bit.
  - On the next cycle, `o_Frame` loads the assembled frame, `o_Valid`=1, and `o_FrameErr`=~stop.
  - Stop=1: go to IDLE.
  - Stop=0: go to WAITHI.
- **WAITHI** (break or line-low recovery)
  - Stay until a tick samples rx=1, then go to IDLE.
  - No start detection while in WAITHI.

Other rules:
- `i_Parity` changes mid-frame have no effect on the current frame.
- A frame is 10 ticks without parity and 11 ticks with parity.

## Timing

- Reset values: `o_Frame`=0, `o_Valid`=0, `o_FrameErr`=0, `o_Busy`=0, state IDLE, counter 0. A reset mid-frame aborts the frame with no `o_Valid`.
- `o_Valid` rises on the clock edge after the cycle that sampled the stop tick, and lasts exactly 1 cycle.
- `o_Frame` is stable from `o_Valid` until the next `o_Valid`.
- `o_Busy` rises on the edge after the start tick and falls on the edge after the stop tick (or after the WAITHI exit tick).
- Back-to-back frames: a start bit on the tick immediately after a good stop tick is accepted, so there is no dead cycle.
- `i_BitEn`=0 freezes all state. A reset asserted in the same cycle as `i_BitEn` wins.

## Configuration

- `USRT_RX_SYNC_EN` defined:
  - `i_Rx` passes through a two-flop synchronizer, reset to 1, before sampling.
  - The sampled value is `i_Rx` delayed 2 `i_Pclk` cycles.
- Not defined: `i_Rx` is sampled directly, with no added latency.
- Frame layout and state behaviour are identical in both builds.

## Test plan

All scenarios use a tick every 4 cycles and line bits LSB first.
- No parity (00), data 0xA5, stop 1 -> one `o_Valid` pulse, `o_Frame`=11'h295, `o_FrameErr`=0, 10 ticks from start to stop.
- Even parity (01), data 0x07, parity bit 1 -> `o_Frame`=11'h41D. Odd parity (10), data 0x01, parity bit 0 -> `o_Frame`=11'h005. The framer does not judge parity.
- Stop bit 0, data 0x3C, no parity -> `o_Frame`=11'h0F0, `o_FrameErr`=1. Holding the line low for 5 more ticks gives no new frame. The first high tick returns to IDLE, and a following frame 0x55 decodes as 11'h155.
- Two frames back-to-back with no idle tick, 0x00 then 0xFF -> two `o_Valid` pulses, frames 11'h001 then 11'h3FD.
- Reset asserted after the 4th data tick -> no `o_Valid`, all outputs 0. The next full frame 0x81 decodes correctly as 11'h205.
- `i_BitEn` tied high (tick every cycle), data 0xC3 no parity -> 11'h30D. With `USRT_RX_SYNC_EN` the `o_Valid` pulse is 2 cycles later than without it.
